// File: rtl/da_dct_sequencer_pkg.sv
// Shared widths, FSM state type and ROM address fold for the bit-serial DA DCT sequencer.
package da_dct_pkg;

    localparam int DA_DATA_W   = 16;
    localparam int DA_ROM_W    = 16;
    localparam int DA_ROM_FRAC = 14;
    localparam int DA_ACC_W    = 33;

    typedef enum logic [1:0] {IDLE, RUN, DONE} da_state_t;

    // The ROM holds only half the table: a set x0 bit selects the complemented
    // address, and the word read there is used negated.
    function automatic logic [2:0] fold_addr(input logic x0j, input logic [2:0] a);
        return x0j ? ~a : a;
    endfunction

endpackage

// File: rtl/da_dct_sequencer_if.sv
// Sample-group input, half-coefficient ROM port and coefficient output of the DA sequencer.
interface da_dct_sequencer_if #(
    parameter int DATA_W = da_dct_pkg::DA_DATA_W,
    parameter int ROM_W  = da_dct_pkg::DA_ROM_W,
    parameter int ACC_W  = da_dct_pkg::DA_ACC_W
) ();

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] x0;
    logic signed [DATA_W-1:0] x1;
    logic signed [DATA_W-1:0] x2;
    logic signed [DATA_W-1:0] x3;
    logic [2:0]               rom_addr;
    logic                     rom_cs;
    logic signed [ROM_W-1:0]  rom_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  coef;
    logic                     busy;

    modport master (
        output in_valid, x0, x1, x2, x3, rom_data, out_ready,
        input  in_ready, rom_addr, rom_cs, out_valid, coef, busy
    );

    modport slave (
        input  in_valid, x0, x1, x2, x3, rom_data, out_ready,
        output in_ready, rom_addr, rom_cs, out_valid, coef, busy
    );

endinterface

// File: rtl/da_dct_sequencer_bit_slicer.sv
// Holds the four sample shift registers and the bit counter; presents one bit column per cycle, MSB first.
module da_bit_slicer
    import da_dct_pkg::*;
#(
    parameter int DATA_W = DA_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] x0,
    input  logic [DATA_W-1:0] x1,
    input  logic [DATA_W-1:0] x2,
    input  logic [DATA_W-1:0] x3,
    output logic [3:0]        bits,
    output logic              first_bit,
    output logic              last_bit
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [CNT_W-1:0]  bitcnt;
    logic [DATA_W-1:0] sr0, sr1, sr2, sr3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt <= '0;
        end else if (load) begin
            bitcnt <= CNT_W'(DATA_W - 1);
        end else if (shift && bitcnt != '0) begin
            bitcnt <= bitcnt - CNT_W'(1);
        end
    end

    // Shifting left keeps bit[bitcnt] of every sample in the MSB position.
    always_ff @(posedge clk) begin
        if (load) begin
            sr0 <= x0;
            sr1 <= x1;
            sr2 <= x2;
            sr3 <= x3;
        end else if (shift) begin
            sr0 <= {sr0[DATA_W-2:0], 1'b0};
            sr1 <= {sr1[DATA_W-2:0], 1'b0};
            sr2 <= {sr2[DATA_W-2:0], 1'b0};
            sr3 <= {sr3[DATA_W-2:0], 1'b0};
        end
    end

    assign bits      = {sr0[DATA_W-1], sr1[DATA_W-1], sr2[DATA_W-1], sr3[DATA_W-1]};
    assign first_bit = (bitcnt == CNT_W'(DATA_W - 1));
    assign last_bit  = (bitcnt == '0);

endmodule

// File: rtl/da_dct_sequencer.sv
// Bit-serial distributed-arithmetic sequencer: one DCT coefficient per 4-sample group,
// shift-accumulating folded half-coefficient ROM terms MSB first.
module da_dct_sequencer
    import da_dct_pkg::*;
#(
    parameter int DATA_W   = DA_DATA_W,
    parameter int ROM_W    = DA_ROM_W,
    parameter int ROM_FRAC = DA_ROM_FRAC,
    parameter int ACC_W    = DA_ACC_W
) (
    input logic               clk,
    input logic               rst_n,
    da_dct_sequencer_if.slave bus
);

    if (ACC_W < DATA_W + ROM_W + 1 || ROM_FRAC >= ROM_W) begin : g_param_check
        $error("da_dct_sequencer: ACC_W too narrow or ROM_FRAC out of range");
    end

    da_state_t               state, state_nxt;
    logic                    accept, step;
    logic [3:0]              bits;
    logic                    first_bit, last_bit;
    logic signed [ACC_W-1:0] acc, rom_ext, term;

    da_bit_slicer #(.DATA_W(DATA_W)) u_slicer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .shift     (step),
        .x0        (bus.x0),
        .x1        (bus.x1),
        .x2        (bus.x2),
        .x3        (bus.x3),
        .bits      (bits),
        .first_bit (first_bit),
        .last_bit  (last_bit)
    );

    assign accept = (state == IDLE) && bus.in_valid;
    assign step   = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.rom_cs    = 1'b0;
        bus.rom_addr  = 3'b000;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = RUN;
            end
            RUN: begin
                bus.rom_cs   = 1'b1;
                bus.rom_addr = fold_addr(bits[3], bits[2:0]);
                bus.busy     = 1'b1;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Negation happens at full accumulator width so the most negative ROM word cannot wrap.
    assign rom_ext = {{(ACC_W-ROM_W){bus.rom_data[ROM_W-1]}}, bus.rom_data};
    assign term    = bits[3] ? -rom_ext : rom_ext;

    // The sign-bit column carries weight -2^(DATA_W-1), so it seeds the accumulator negated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept) begin
            acc <= '0;
        end else if (step) begin
            acc <= first_bit ? -term : (acc <<< 1) + term;
        end
    end

    assign bus.coef = acc;

endmodule
